mdu: RTL

MDU -- requirements
Module: mdu

---
 rtl/mdu_pkg.sv | 26 ++
 rtl/mdu_negate.sv | 12 +
 rtl/mdu.sv | 124 ++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and the iteration bound.
package mdu_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10
  } state_e;

  localparam int DEF_WIDTH = 32;

  function automatic int iter_last(input int width);
    return width - 1;
  endfunction

  localparam int ITER_LAST = iter_last(DEF_WIDTH);

endpackage

// File: rtl/mdu_negate.sv
// Conditional two's-complement negation of an N-bit value.
module mdu_negate #(
  parameter int N = 32
) (
  input  logic         neg,
  input  logic [N-1:0] x,
  output logic [N-1:0] y
);

  assign y = neg ? (~x + {{(N-1){1'b0}}, 1'b1}) : x;

endmodule

// File: rtl/mdu.sv
// Iterative multiply/divide unit with HI/LO result registers and a fixed
// latency of one radix-2 step per bit plus a sign-fix cycle.
//
// state  | meaning
// S_IDLE | waiting for start; mthi/mtlo writes accepted
// S_RUN  | one shift-add / restoring-divide step per edge
// S_FIX  | sign-correct result, write HI/LO, pulse done
module mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int LAST = iter_last(WIDTH);
  localparam int CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_e             state;
  op_e                op_r;
  logic [CW-1:0]      cnt;
  logic               sa, sb, bz;
  logic [WIDTH-1:0]   dv;
  logic [2*WIDTH-1:0] acc;

  logic               a_sgn, b_sgn;
  logic [WIDTH-1:0]   a_mag, b_mag, quo_fix, rem_fix;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic               div_take;
  logic [2*WIDTH-1:0] acc_step;

  assign a_sgn = ~op[0] & a[WIDTH-1];
  assign b_sgn = ~op[0] & b[WIDTH-1];

  mdu_negate #(.N(WIDTH))   u_neg_a    (.neg(a_sgn),   .x(a),                       .y(a_mag));
  mdu_negate #(.N(WIDTH))   u_neg_b    (.neg(b_sgn),   .x(b),                       .y(b_mag));
  mdu_negate #(.N(2*WIDTH)) u_neg_prod (.neg(sa ^ sb), .x(acc),                     .y(prod_fix));
  mdu_negate #(.N(WIDTH))   u_neg_quo  (.neg(sa ^ sb), .x(acc[WIDTH-1:0]),          .y(quo_fix));
  mdu_negate #(.N(WIDTH))   u_neg_rem  (.neg(sa),      .x(acc[2*WIDTH-1:WIDTH]),    .y(rem_fix));

  // acc holds {partial product, multiplier} for multiply, {remainder, quotient} for divide
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, dv} : '0);
    div_shift = acc[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, dv};
    // a zero divisor always "fits", shifting the dividend into the remainder untouched
    div_take  = bz | ~div_diff[WIDTH];
    acc_step  = '0;
    if (op_r[1]) begin
      acc_step = {(div_take ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                  acc[WIDTH-2:0], div_take};
    end else begin
      acc_step = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      op_r  <= OP_MULT;
      cnt   <= '0;
      sa    <= 1'b0;
      sb    <= 1'b0;
      bz    <= 1'b0;
      dv    <= '0;
      acc   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            op_r  <= op_e'(op);
            sa    <= a_sgn;
            sb    <= b_sgn;
            bz    <= op[1] & (b == '0);
            dv    <= op[1] ? b_mag : a_mag;
            acc   <= {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end else begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end
        S_RUN: begin
          acc <= acc_step;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(LAST)) state <= S_FIX;
        end
        S_FIX: begin
          if (op_r[1]) begin
            hi <= rem_fix;
            lo <= bz ? '1 : quo_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
